// File: rtl/digital_pll_lock_monitor.sv
// PLL lock monitor: counts PLL clocks per synchronized reference period, checks
// each count against the feedback divider and reports lock / lost-reference status.
module digital_pll_lock_monitor #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8,
   parameter int LOCK_COUNT  = 4,
   parameter int TOL         = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             osc,
   input  logic [4:0]       div,
   output logic [CNT_W-1:0] count_out,
   output logic             count_valid,
   output logic             locked,
   output logic             osc_lost
);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [3:0]       LOCK_TGT = 4'(LOCK_COUNT);
   localparam logic [CNT_W:0]   TOL_W    = (CNT_W+1)'(TOL);

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      MEASURE
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   osc_rise;
   logic [CNT_W-1:0]       cnt;
   logic [3:0]             good_run;
   logic [CNT_W:0]         cnt_ext;
   logic [CNT_W:0]         div_ext;
   logic [CNT_W:0]         diff;
   logic                   in_tol;
   logic [3:0]             good_next;

   // Synchronizer and edge detector run regardless of enable.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], osc};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign osc_rise = sync_q[SYNC_STAGES-1] & ~prev_q;

   always_comb begin
      cnt_ext   = {1'b0, cnt};
      div_ext   = {{(CNT_W-4){1'b0}}, div};
      diff      = (cnt_ext >= div_ext) ? (cnt_ext - div_ext) : (div_ext - cnt_ext);
      in_tol    = (div != 5'd0) && (diff <= TOL_W);
      good_next = (good_run >= LOCK_TGT) ? LOCK_TGT : (good_run + 4'd1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         good_run    <= '0;
         count_out   <= '0;
         count_valid <= 1'b0;
         locked      <= 1'b0;
         osc_lost    <= 1'b0;
      end else if (!enable) begin
         state       <= IDLE;
         cnt         <= '0;
         good_run    <= '0;
         count_out   <= '0;
         count_valid <= 1'b0;
         locked      <= 1'b0;
         osc_lost    <= 1'b0;
      end else begin
         count_valid <= 1'b0;
         case (state)
            IDLE: begin
               cnt   <= '0;
               state <= ARM;
            end
            ARM: begin
               if (osc_rise) begin
                  cnt      <= CNT_ONE;
                  osc_lost <= 1'b0;
                  state    <= MEASURE;
               end else if (cnt == CNT_MAX) begin
                  cnt      <= '0;
                  osc_lost <= 1'b1;
                  locked   <= 1'b0;
                  good_run <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            MEASURE: begin
               // A rise in the saturation cycle is a valid measurement, not a timeout.
               if (osc_rise) begin
                  count_out   <= cnt;
                  count_valid <= 1'b1;
                  cnt         <= CNT_ONE;
                  osc_lost    <= 1'b0;
                  if (in_tol) begin
                     good_run <= good_next;
                     if (good_next == LOCK_TGT)
                        locked <= 1'b1;
                  end else begin
                     good_run <= '0;
                     locked   <= 1'b0;
                  end
               end else if (cnt == CNT_MAX) begin
                  cnt      <= '0;
                  osc_lost <= 1'b1;
                  locked   <= 1'b0;
                  good_run <= '0;
                  state    <= ARM;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_digital_pll_lock_monitor.sv
// Bench for digital_pll_lock_monitor: table of osc periods with expected
// measurements fed through a scoreboard, plus timeout/enable/reset sequences.
module tb_digital_pll_lock_monitor;

   logic       clock = 1'b0;
   logic       reset;
   logic       enable;
   logic       osc;
   logic [4:0] div;
   logic [7:0] count_out;
   logic       count_valid;
   logic       locked;
   logic       osc_lost;

   digital_pll_lock_monitor #(
      .SYNC_STAGES(2),
      .CNT_W(8),
      .LOCK_COUNT(4),
      .TOL(1)
   ) dut (
      .clock(clock),
      .reset(reset),
      .enable(enable),
      .osc(osc),
      .div(div),
      .count_out(count_out),
      .count_valid(count_valid),
      .locked(locked),
      .osc_lost(osc_lost)
   );

   always #5 clock = ~clock;

   typedef struct {
      int period;
      int exp_cnt;
      int exp_lck;
   } vec_t;

   typedef struct {
      int cnt;
      int lck;
   } exp_t;

   vec_t tab[35];
   exp_t sb[$];
   exp_t pend;
   bit   have_pend;
   int   n_tests;
   int   n_fail;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Every count_valid must match the oldest outstanding expectation.
   always @(negedge clock) begin : monitor
      exp_t e;
      if (count_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_count_valid", 1, 0);
         end else begin
            e = sb.pop_front();
            check("count_out", int'(count_out), e.cnt);
            check("locked_at_valid", int'(locked), e.lck);
            check("osc_lost_at_valid", int'(osc_lost), 0);
         end
      end
   end

   task automatic fill(input int i, input int p, input int l);
      tab[i] = '{period: p, exp_cnt: p, exp_lck: l};
   endtask

   // Drive one osc rise followed by a period of p clocks; the rise closes the
   // previous period, whose expectation is queued now.
   task automatic do_rise(input int p, input int ec, input int el);
      int hi;
      hi  = p / 2;
      osc = 1'b1;
      if (have_pend) sb.push_back(pend);
      pend      = '{cnt: ec, lck: el};
      have_pend = 1'b1;
      repeat (hi) @(posedge clock);
      #1 osc = 1'b0;
      repeat (p - hi) @(posedge clock);
      #1;
   endtask

   task automatic final_rise();
      osc = 1'b1;
      if (have_pend) sb.push_back(pend);
      have_pend = 1'b0;
      repeat (2) @(posedge clock);
      #1 osc = 1'b0;
      repeat (4) @(posedge clock);
      #1;
   endtask

   task automatic run_range(input int lo, input int hi);
      for (int i = lo; i <= hi; i++)
         do_rise(tab[i].period, tab[i].exp_cnt, tab[i].exp_lck);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

   initial begin : stim
      int n;
      n_tests   = 0;
      n_fail    = 0;
      have_pend = 1'b0;

      // A: div=8 lock, loss at 11, relock, tolerance edges 7/9, reject 10
      fill(0, 8, 0);  fill(1, 8, 0);  fill(2, 8, 0);  fill(3, 8, 1);
      fill(4, 11, 0);
      fill(5, 8, 0);  fill(6, 8, 0);  fill(7, 8, 0);  fill(8, 8, 1);
      fill(9, 10, 0);
      fill(10, 7, 0); fill(11, 9, 0); fill(12, 7, 0); fill(13, 9, 1);
      fill(14, 10, 0);
      fill(15, 8, 0); fill(16, 8, 0); fill(17, 8, 0); fill(18, 8, 1);
      // B: relock after timeout
      fill(19, 8, 0); fill(20, 8, 0); fill(21, 8, 0); fill(22, 8, 1);
      // C: relock after re-enable
      fill(23, 8, 0); fill(24, 8, 0); fill(25, 8, 0); fill(26, 8, 1);
      // D: div=0 never locks
      fill(27, 8, 0); fill(28, 8, 0); fill(29, 8, 0); fill(30, 8, 0);
      fill(31, 8, 0); fill(32, 2, 0); fill(33, 254, 0);
      // E: rise coincident with saturation
      fill(34, 255, 0);

      reset  = 1'b1;
      enable = 1'b0;
      osc    = 1'b0;
      div    = 5'd8;
      repeat (3) @(posedge clock);
      #1;
      check("reset_count_out", int'(count_out), 0);
      check("reset_count_valid", int'(count_valid), 0);
      check("reset_locked", int'(locked), 0);
      check("reset_osc_lost", int'(osc_lost), 0);

      reset  = 1'b0;
      enable = 1'b1;
      @(posedge clock);
      #1;
      run_range(0, 18);

      // Timeout: last rise, then osc held low until the counter saturates.
      osc = 1'b1;
      if (have_pend) sb.push_back(pend);
      have_pend = 1'b0;
      n = 0;
      for (int k = 1; k <= 400; k++) begin
         @(posedge clock);
         #1;
         if (k == 2) osc = 1'b0;
         if (k == 5) check("locked_before_timeout", int'(locked), 1);
         if (osc_lost) begin
            n = k;
            break;
         end
      end
      check("timeout_latency", n, 258);
      check("timeout_locked", int'(locked), 0);
      check("timeout_count_valid", int'(count_valid), 0);

      run_range(19, 19);
      check("osc_lost_cleared_on_arm", int'(osc_lost), 0);
      run_range(20, 22);
      final_rise();
      check("relock_after_timeout", int'(locked), 1);

      // Disable mid-period
      repeat (2) @(posedge clock);
      #1 enable = 1'b0;
      @(posedge clock);
      #1;
      check("disable_count_out", int'(count_out), 0);
      check("disable_locked", int'(locked), 0);
      check("disable_osc_lost", int'(osc_lost), 0);
      check("disable_count_valid", int'(count_valid), 0);
      repeat (3) @(posedge clock);
      #1 enable = 1'b1;
      @(posedge clock);
      #1;
      run_range(23, 26);
      final_rise();
      check("relock_after_enable", int'(locked), 1);

      // Reset while locked with enable held high
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("midreset_count_out", int'(count_out), 0);
      check("midreset_locked", int'(locked), 0);
      check("midreset_osc_lost", int'(osc_lost), 0);
      check("midreset_count_valid", int'(count_valid), 0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      div = 5'd0;
      @(posedge clock);
      #1;
      run_range(27, 33);
      final_rise();
      check("div0_locked", int'(locked), 0);

      enable = 1'b0;
      repeat (2) @(posedge clock);
      #1 div = 5'd8;
      enable = 1'b1;
      @(posedge clock);
      #1;
      run_range(34, 34);
      final_rise();
      check("sat_rise_osc_lost", int'(osc_lost), 0);
      check("sat_rise_locked", int'(locked), 0);

      repeat (5) @(posedge clock);
      #1;
      check("scoreboard_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
